// File: rtl/weight_sched_pkg.sv
// Shared constants for the weight-request sequencer and the weight-request datapath.
package weight_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned MAX_OUTST_DEF = 2;

  // One weight group is a kernel x channel word of 12 byte lanes.
  localparam int unsigned DAT_WIDTH  = 8;
  localparam int unsigned KC_LANES   = 12;
  localparam int unsigned WGRP_WIDTH = DAT_WIDTH * KC_LANES;

endpackage

// File: rtl/weight_sched_credit_cnt.sv
// Outstanding-request counter: simultaneous request and return cancel out.
module credit_cnt #(
  parameter int unsigned LIMIT = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic below_limit,
  output logic underflow
);

  localparam logic [WIDTH:0] LIM = (WIDTH+1)'(LIMIT);

  logic [WIDTH-1:0] cnt;

  assign below_limit = ({1'b0, cnt} < LIM);
  // A return with nothing in flight and no same-cycle request has no owner.
  assign underflow   = dec & ~inc & (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/weight_sched.sv
// Per-layer sequencer: clears the weight-request block, issues credit-limited
// requests and counts returned weight groups until the layer completes.
module weight_sched
  import weight_pkg::*;
#(
  parameter int unsigned REG_WIDTH   = 32,
  parameter int unsigned MAX_OUTST   = MAX_OUTST_DEF,
  parameter int unsigned OUTST_WIDTH = 2,
  parameter int unsigned CLR_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [REG_WIDTH-1:0] i_num_grp,
  input  logic                 i_pe_rdy,
  input  logic                 i_wvld,
  output logic                 o_wreq,
  output logic                 o_wclr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [REG_WIDTH-1:0] o_req_cnt,
  output logic [REG_WIDTH-1:0] o_vld_cnt
);

  localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t               state, state_nxt;
  logic [REG_WIDTH-1:0] num, req_cnt, vld_cnt;
  logic [CLR_W-1:0]     clr_cnt;
  logic                 err;

  logic start_acc, wreq, vld_acc, below_limit, underflow;
  logic req_last, vld_last;

  assign start_acc = (state == IDLE) && i_start;
  assign wreq      = (state == RUN) && (req_cnt < num) && i_pe_rdy && (below_limit || i_wvld);
  assign vld_acc   = i_wvld && !underflow && (state == RUN || state == DRAIN);
  assign req_last  = wreq && (({1'b0, req_cnt} + 1'b1) == {1'b0, num});
  assign vld_last  = (vld_cnt == num) || (vld_acc && (({1'b0, vld_cnt} + 1'b1) == {1'b0, num}));

  credit_cnt #(
    .LIMIT (MAX_OUTST),
    .WIDTH (OUTST_WIDTH)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .clr         (start_acc),
    .inc         (wreq),
    .dec         (i_wvld),
    .below_limit (below_limit),
    .underflow   (underflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      num     <= '0;
      req_cnt <= '0;
      vld_cnt <= '0;
      clr_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= (state == CLR) ? clr_cnt + 1'b1 : '0;
      if (underflow) err <= 1'b1;
      if (start_acc) begin
        num     <= i_num_grp;
        req_cnt <= '0;
        vld_cnt <= '0;
      end else begin
        if (wreq && req_cnt != '1) req_cnt <= req_cnt + 1'b1;
        if (vld_acc && vld_cnt != '1) vld_cnt <= vld_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (i_start) state_nxt = (i_num_grp == '0) ? DONE : CLR;
      CLR:   if (clr_cnt == CLR_LAST) state_nxt = RUN;
      // A stall-slot return on the final request can complete the layer from RUN.
      RUN:   if (req_last) state_nxt = vld_last ? DONE : DRAIN;
      DRAIN: if (vld_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_wreq    = wreq;
  assign o_wclr    = (state == CLR);
  assign o_busy    = (state == CLR) || (state == RUN) || (state == DRAIN);
  assign o_done    = (state == DONE);
  assign o_err     = err;
  assign o_req_cnt = req_cnt;
  assign o_vld_cnt = vld_cnt;

endmodule

// File: tb/tb_weight_sched.sv
// Directed bench for weight_sched with a latency-programmable weight-return responder.
module tb_weight_sched;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_num_grp;
  logic        i_pe_rdy = 1'b0;
  logic        i_wvld = 1'b0;
  logic        o_wreq, o_wclr, o_busy, o_done, o_err;
  logic [31:0] o_req_cnt, o_vld_cnt;

  always #5 clk = ~clk;

  weight_sched #(
    .REG_WIDTH   (32),
    .MAX_OUTST   (MAXO),
    .OUTST_WIDTH (2),
    .CLR_CYCLES  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_num_grp (i_num_grp),
    .i_pe_rdy  (i_pe_rdy),
    .i_wvld    (i_wvld),
    .o_wreq    (o_wreq),
    .o_wclr    (o_wclr),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_req_cnt (o_req_cnt),
    .o_vld_cnt (o_vld_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int unsigned num;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Responder configuration (written by the stimulus block only).
  int lat = 1;
  bit stall4 = 0;
  int rdy_mode = 0;
  int cur_num = 0;
  int spur_req = 0;
  int flush_req = 0;

  // Responder/monitor state (written by the monitor only).
  int cyc = 0, nwreq = 0, nvld = 0, nwclr = 0, nreq_nordy = 0;
  int out_viol = 0, gaps = 0, last_vld_cyc = 0, tb_out = 0;
  int spur_ack = 0, flush_ack = 0;
  logic [15:0] pend = '0;

  // Layer snapshots.
  int b_wreq = 0, b_vld = 0, b_wclr = 0, b_nordy = 0, b_viol = 0, b_gaps = 0;
  int start_cyc = 0, done_at = 0;
  logic exp_err = 1'b0;

  always @(negedge clk) begin
    int k;
    bit sp;
    cyc++;
    sp = 0;
    if (flush_req != flush_ack) begin
      flush_ack = flush_req;
      pend = '0;
      tb_out = 0;
    end
    case (rdy_mode)
      0:       i_pe_rdy = 1'b1;
      1:       i_pe_rdy = (cyc % 2 == 0);
      default: i_pe_rdy = ((cyc / 2) % 2 == 0);
    endcase
    i_wvld = pend[0];
    pend = pend >> 1;
    if (spur_req != spur_ack) begin
      spur_ack = spur_req;
      i_wvld = 1'b1;
      sp = 1;
    end
    #1;
    if (o_wreq) begin
      nwreq++;
      tb_out++;
      if (!i_pe_rdy) nreq_nordy++;
      if (stall4 && ((nwreq - b_wreq) % 4 == 0) && !i_wvld) begin
        i_wvld = 1'b1;
      end else begin
        k = lat - 1;
        while (k < 15 && pend[k]) k++;
        pend[k] = 1'b1;
      end
    end
    #1;
    if (i_wvld && !sp) begin
      nvld++;
      tb_out--;
      last_vld_cyc = cyc;
    end
    if (o_wclr) nwclr++;
    if (tb_out > MAXO) out_viol++;
    if (o_busy && i_pe_rdy && !o_wreq && !o_wclr && o_req_cnt < cur_num) gaps++;
  end

  task automatic start_layer(input int n);
    exp_t e;
    @(negedge clk);
    #3;
    start_cyc = cyc;
    b_wreq = nwreq; b_vld = nvld; b_wclr = nwclr;
    b_nordy = nreq_nordy; b_viol = out_viol; b_gaps = gaps;
    cur_num = n;
    e.num = n;
    e.err = exp_err;
    sb.push_back(e);
    i_num_grp = n;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_num_grp = 32'hdead_beef;
  endtask

  task automatic wait_done(input string tag, input int budget);
    exp_t e;
    for (int i = 0; i < budget; i++) begin
      #3;
      if (o_done) break;
      @(negedge clk);
    end
    done_at = cyc;
    check({tag, "_done"}, o_done, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_req_cnt"}, o_req_cnt, e.num);
      check({tag, "_vld_cnt"}, o_vld_cnt, e.num);
      check({tag, "_err"}, o_err, e.err);
    end
    check({tag, "_busy_at_done"}, o_busy, 0);
    @(negedge clk);
    #3;
    check({tag, "_done_pulse"}, o_done, 0);
    @(negedge clk);
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    i_start = 1'b0;
    i_num_grp = '0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_ctrl", {o_wreq, o_wclr, o_busy, o_done, o_err}, 0);
    check("rst_req_cnt", o_req_cnt, 0);
    check("rst_vld_cnt", o_vld_cnt, 0);
    rst = 1'b0;

    // 12 groups, one-cycle return.
    lat = 1; stall4 = 0; rdy_mode = 0;
    start_layer(12);
    wait_done("t1", 200);
    check("t1_wclr_cycles", nwclr - b_wclr, 1);
    check("t1_wreqs", nwreq - b_wreq, 12);
    check("t1_valids", nvld - b_vld, 12);
    check("t1_done_after_last", done_at - last_vld_cyc, 1);

    // 8 groups, three-cycle return: credit limit throttles; second start ignored.
    lat = 3;
    start_layer(8);
    repeat (3) @(negedge clk);
    #3;
    check("t2_busy_mid", o_busy, 1);
    i_num_grp = 99;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("t2", 300);
    check("t2_outst_viol", out_viol - b_viol, 0);
    check("t2_gaps_seen", (gaps > b_gaps) ? 1 : 0, 1);
    check("t2_wreqs", nwreq - b_wreq, 8);
    check("t2_done_after_last", done_at - last_vld_cyc, 1);

    // 16 groups, every 4th return lands in the stall slot of its own request.
    lat = 1; stall4 = 1; rdy_mode = 1;
    start_layer(16);
    wait_done("t3", 300);
    check("t3_valids", nvld - b_vld, 16);
    check("t3_outst_viol", out_viol - b_viol, 0);
    check("t3_done_after_last", done_at - last_vld_cyc, 1);
    stall4 = 0;

    // 6 groups, PE ready toggling every 2 cycles.
    rdy_mode = 2;
    start_layer(6);
    wait_done("t4", 300);
    check("t4_wreq_without_rdy", nreq_nordy - b_nordy, 0);
    check("t4_wreqs", nwreq - b_wreq, 6);
    rdy_mode = 0;

    // Empty layer.
    start_layer(0);
    wait_done("t5", 10);
    check("t5_done_latency", done_at - start_cyc, 1);
    check("t5_wclr", nwclr - b_wclr, 0);
    check("t5_wreqs", nwreq - b_wreq, 0);

    // Spurious return in IDLE sets a sticky error that survives a full layer.
    @(negedge clk);
    #3;
    spur_req++;
    @(negedge clk);
    @(negedge clk);
    #3;
    check("t6_err_set", o_err, 1);
    check("t6_vld_cnt_ignored", o_vld_cnt, 0);
    exp_err = 1'b1;
    lat = 2;
    start_layer(4);
    wait_done("t6", 200);

    // Reset while in RUN once three requests have been issued.
    lat = 1;
    start_layer(20);
    for (int i = 0; i < 50; i++) begin
      #3;
      if (o_req_cnt == 3) break;
      @(negedge clk);
    end
    check("t7_req_cnt_before_rst", o_req_cnt, 3);
    rst = 1'b1;
    flush_req++;
    @(negedge clk);
    #3;
    check("t7_rst_ctrl", {o_wreq, o_wclr, o_busy, o_done, o_err}, 0);
    check("t7_rst_req_cnt", o_req_cnt, 0);
    check("t7_rst_vld_cnt", o_vld_cnt, 0);
    rst = 1'b0;
    void'(sb.pop_back());
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #3;
      if (o_done) nd++;
    end
    check("t7_no_done_after_rst", nd, 0);
    check("t7_idle_after_rst", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_sched.md
Name: weight_sched

Overview:
- Sequencer for the weight-request datapath (the block that turns i_req into aligned 96-bit kernel×channel weight words).
- Per layer, given a group count, it:
  - clears the request block,
  - issues exactly that many weight requests, throttled by PE readiness and an outstanding-request credit limit,
  - counts returned valid words and signals layer completion.
- Sits between the layer controller/register file and the weight-request block feeding the KCPE array.

Parameters:
- REG_WIDTH, 32, width of count configuration and status counters
- MAX_OUTST, 2, maximum requests in flight (issued but not yet returned valid)
- OUTST_WIDTH, 2, counter width for outstanding requests; must hold MAX_OUTST
- CLR_CYCLES, 1, number of cycles o_wclr is held high before the first request

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_start  input  1  one-cycle pulse; latch i_num_grp and begin a layer
- i_num_grp  input  REG_WIDTH  number of weight groups (o_vld beats) to deliver
- i_pe_rdy  input  1  KCPE array can accept a weight group next cycle
- i_wvld  input  1  weight-request block output valid
- o_wreq  output  1  request strobe to the weight-request block (drives its i_req)
- o_wclr  output  1  synchronous clear to the weight-request block (ORed into its rst)
- o_busy  output  1  high from accepted start until done
- o_done  output  1  one-cycle pulse when the last group has returned
- o_err  output  1  sticky; valid returned with no request outstanding
- o_req_cnt  output  REG_WIDTH  requests issued in the current layer
- o_vld_cnt  output  REG_WIDTH  valids received in the current layer

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - all outputs 0
  - state IDLE
  - outstanding counter 0
  - latched count 0
- FSM states: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE:
  - i_start moves to CLR; latch i_num_grp; zero o_req_cnt, o_vld_cnt and outstanding; o_err is not cleared.
  - i_start with i_num_grp==0 moves directly to DONE (o_done next cycle; no o_wclr, no o_wreq).
- CLR:
  - o_wclr high for CLR_CYCLES cycles, then RUN.
  - o_wreq is low throughout CLR.
- RUN:
  - o_wreq is combinational: state==RUN & req_cnt<num & i_pe_rdy & (outst<MAX_OUTST | i_wvld).
  - A same-cycle returning valid frees a credit.
  - When req_cnt reaches num after an issue, move to DRAIN.
- DRAIN:
  - o_wreq=0.
  - When vld_cnt==num (including the cycle the final valid arrives), move to DONE.
- DONE: o_done=1 for one cycle, o_busy drops in that cycle, then IDLE.
- o_busy = (state != IDLE && state != DONE) for non-zero layers.
- Outstanding counter:
  - +1 on o_wreq alone, −1 on i_wvld alone, unchanged when both occur.
  - Never exceeds MAX_OUTST.
- The weight-request block asserts o_vld in its stall slot in the same cycle as i_req. That case is the simultaneous-event case above and must not over- or under-count.
- i_wvld with outst==0 and no same-cycle o_wreq: set o_err (sticky until rst), ignore the beat for counting.
- i_wvld in IDLE: same error rule.
- i_start while busy: ignored; latched count unchanged.
- i_pe_rdy low: stalls issue only; valids already in flight are still counted.
- Counters saturate at 2^REG_WIDTH−1; the layer size limit is 2^REG_WIDTH−1 groups.
- rst mid-layer: everything returns to reset values next cycle; no o_done. o_wclr is not asserted by reset itself (the downstream block sees rst directly).

Decomposition:
- Shared package weight_pkg:
  - FSM state encoding constants (IDLE=0, CLR=1, RUN=2, DRAIN=3, DONE=4; 3 bits)
  - default MAX_OUTST
  - DAT/weight-group width constants shared with the weight-request block
- One natural sub-module, credit_cnt: up/down outstanding counter with simultaneous inc/dec, limit compare and underflow flag.

Test Plan:
- num=12, pe_rdy=1, valid returns 1 cycle after each request:
  - o_wclr high exactly 1 cycle; 12 o_wreq, 12 valids
  - o_done pulses once, 1 cycle after the 12th valid
  - o_req_cnt=o_vld_cnt=12, o_err=0
- num=8, valid latency 3 cycles, MAX_OUTST=2:
  - never more than 2 requests outstanding
  - o_wreq gaps appear
  - done after the 8th valid
- Stall-slot pattern, valid same-cycle with every 4th request, num=16:
  - outstanding never underflows, o_err=0
  - o_vld_cnt ends at 16
- pe_rdy toggling 1/0 every 2 cycles, num=6:
  - o_wreq only in cycles with pe_rdy=1
  - 6 requests total, done asserted
- num=0 start: o_done next cycle, no o_wclr, no o_wreq. Second start asserted mid-layer: ignored.
- Spurious i_wvld in IDLE: o_err=1 and stays high through a subsequent layer. Assert rst in RUN at req_cnt=3: all outputs 0 next cycle, no o_done.
